// File: rtl/star_box_finder.sv
// Raster-scans the stored image, thresholds each pixel and finds the bounding box
// of all bright pixels, then hands the box to the cleaner via goClean/doneClean.
module star_box_finder #(
    parameter int xSz   = 3,
    parameter int ySz   = 3,
    parameter int colSz = 3,
    parameter int XMAX  = 7,
    parameter int YMAX  = 7
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [colSz-1:0] thresh,
    output logic [xSz-1:0]   rdX,
    output logic [ySz-1:0]   rdY,
    input  logic [colSz-1:0] rdData,
    output logic [xSz-1:0]   xLeft,
    output logic [xSz-1:0]   xRight,
    output logic [ySz-1:0]   yTop,
    output logic [ySz-1:0]   yBottom,
    output logic             goClean,
    input  logic             doneClean,
    output logic             busy,
    output logic             found,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE, S_SCAN, S_DRAIN, S_EVAL, S_GO_CLEAN, S_WAIT_LOW, S_WAIT_HIGH, S_DONE
    } state_t;

    localparam logic [xSz-1:0] LP_XMAX = xSz'(XMAX);
    localparam logic [ySz-1:0] LP_YMAX = ySz'(YMAX);

    state_t           r_state;
    logic [xSz-1:0]   r_rdx, r_sx, r_minx, r_maxx, r_xleft, r_xright;
    logic [ySz-1:0]   r_rdy, r_sy, r_miny, r_maxy, r_ytop, r_ybottom;
    logic             r_valid, r_hit;
    logic             r_goclean, r_busy, r_found, r_done;
    logic             w_mark;

    // The sample on rdData belongs to the address registered in (r_sx, r_sy).
    assign w_mark = r_valid && (rdData >= thresh);

    // NOTE: all state uses non-blocking assignments and the async reset clears every register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_rdx     <= '0;
            r_rdy     <= '0;
            r_sx      <= '0;
            r_sy      <= '0;
            r_valid   <= 1'b0;
            r_hit     <= 1'b0;
            r_minx    <= '0;
            r_maxx    <= '0;
            r_miny    <= '0;
            r_maxy    <= '0;
            r_xleft   <= '0;
            r_xright  <= '0;
            r_ytop    <= '0;
            r_ybottom <= '0;
            r_goclean <= 1'b0;
            r_busy    <= 1'b0;
            r_found   <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_valid   <= (r_state == S_SCAN);
            r_sx      <= r_rdx;
            r_sy      <= r_rdy;
            r_goclean <= 1'b0;
            r_done    <= 1'b0;

            if (w_mark) begin
                r_hit <= 1'b1;
                if (r_sx < r_minx) r_minx <= r_sx;
                if (r_sx > r_maxx) r_maxx <= r_sx;
                if (r_sy < r_miny) r_miny <= r_sy;
                if (r_sy > r_maxy) r_maxy <= r_sy;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_SCAN;
                        r_rdx   <= '0;
                        r_rdy   <= '0;
                        r_minx  <= '1;
                        r_miny  <= '1;
                        r_maxx  <= '0;
                        r_maxy  <= '0;
                        r_hit   <= 1'b0;
                        r_found <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                S_SCAN: begin
                    if (r_rdx == LP_XMAX) begin
                        r_rdx <= '0;
                        if (r_rdy == LP_YMAX) r_state <= S_DRAIN;
                        else                  r_rdy   <= r_rdy + 1'b1;
                    end else begin
                        r_rdx <= r_rdx + 1'b1;
                    end
                end
                S_DRAIN: r_state <= S_EVAL;
                S_EVAL: begin
                    r_found <= r_hit;
                    if (r_hit) begin
                        r_xleft   <= r_minx;
                        r_xright  <= r_maxx;
                        r_ytop    <= r_miny;
                        r_ybottom <= r_maxy;
                        r_goclean <= 1'b1;
                        r_state   <= S_GO_CLEAN;
                    end else begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_GO_CLEAN: r_state <= S_WAIT_LOW;
                S_WAIT_LOW: if (!doneClean) r_state <= S_WAIT_HIGH;
                S_WAIT_HIGH: begin
                    if (doneClean) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rdX     = r_rdx;
    assign rdY     = r_rdy;
    assign xLeft   = r_xleft;
    assign xRight  = r_xright;
    assign yTop    = r_ytop;
    assign yBottom = r_ybottom;
    assign goClean = r_goclean;
    assign busy    = r_busy;
    assign found   = r_found;
    assign done    = r_done;

endmodule

// File: tb/tb_star_box_finder.sv
// Self-checking bench for star_box_finder: image memory and cleaner models plus
// a loop-based bounding-box reference computed straight from the pixel array.
module tb_star_box_finder;

    localparam int N = 64;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic [2:0] thresh = 3'd0;
    logic [2:0] rdX, rdY, rdData;
    logic [2:0] xLeft, xRight, yTop, yBottom;
    logic       goClean, doneClean, busy, found, done;

    int errors = 0;
    int checks = 0;

    logic [2:0] mem [0:7][0:7];   // [y][x]
    int clean_len = 10;
    int clean_cnt;

    // expected box outputs (persist across runs without a hit)
    int exp_xl = 0, exp_xr = 0, exp_yt = 0, exp_yb = 0;

    // measurements of one scan
    int gc_cyc, gc_cnt, dn_cyc, dn_cnt, addr_err;
    logic busy_first, busy_after;

    always #5 clk = ~clk;

    star_box_finder dut (
        .clk(clk), .resetn(resetn), .start(start), .thresh(thresh),
        .rdX(rdX), .rdY(rdY), .rdData(rdData),
        .xLeft(xLeft), .xRight(xRight), .yTop(yTop), .yBottom(yBottom),
        .goClean(goClean), .doneClean(doneClean),
        .busy(busy), .found(found), .done(done)
    );

    always @(posedge clk) rdData <= mem[rdY][rdX];

    // Cleaner: leaves idle the cycle after goClean, stays busy clean_len cycles.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            doneClean <= 1'b1;
            clean_cnt <= 0;
        end else if (goClean) begin
            doneClean <= 1'b0;
            clean_cnt <= clean_len;
        end else if (clean_cnt > 1) begin
            clean_cnt <= clean_cnt - 1;
        end else if (clean_cnt == 1) begin
            clean_cnt <= 0;
            doneClean <= 1'b1;
        end
    end

    task automatic fill(input logic [2:0] v);
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++)
                mem[y][x] = v;
    endtask

    // Reference: bounding box of every pixel at or above th.
    task automatic model(input logic [2:0] th, output bit hit);
        int xl, xr, yt, yb;
        hit = 0; xl = 99; xr = -1; yt = 99; yb = -1;
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++)
                if (mem[y][x] >= th) begin
                    hit = 1;
                    if (x < xl) xl = x;
                    if (x > xr) xr = x;
                    if (y < yt) yt = y;
                    if (y > yb) yb = y;
                end
        if (hit) begin
            exp_xl = xl; exp_xr = xr; exp_yt = yt; exp_yb = yb;
        end
    endtask

    // Runs one scan starting now; s1/s2 are extra cycles where start is pulsed.
    task automatic run_scan(input int s1, input int s2);
        @(negedge clk);
        start = 1'b1;
        gc_cyc = -1; gc_cnt = 0; dn_cyc = -1; dn_cnt = 0; addr_err = 0;
        busy_first = 1'b0; busy_after = 1'b1;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            start = (c == s1 || c == s2);
            if (c <= N && (int'(rdX) != (c - 1) % 8 || int'(rdY) != (c - 1) / 8))
                addr_err++;
            if (c == 1) busy_first = busy;
            if (goClean) begin gc_cnt++; gc_cyc = c; end
            if (done) begin dn_cnt++; dn_cyc = c; end
            if (dn_cyc >= 0 && c == dn_cyc + 1) busy_after = busy;
            if (dn_cyc >= 0 && c >= dn_cyc + 4) break;
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        checks++;
        if ({rdX, rdY, xLeft, xRight, yTop, yBottom} !== 18'd0) begin
            errors++; $display("FAIL reset_addr_box got=%h exp=0", {rdX, rdY, xLeft, xRight, yTop, yBottom});
        end
        checks++;
        if ({goClean, busy, found, done} !== 4'd0) begin
            errors++; $display("FAIL reset_flags got=%b exp=0000", {goClean, busy, found, done});
        end
    endtask

    task automatic test_single_star;
        bit hit;
        fill(3'd0); mem[2][3] = 3'd7; thresh = 3'd4; clean_len = 10;
        model(thresh, hit);
        run_scan(0, 0);
        checks++;
        if (gc_cnt !== 1 || gc_cyc !== N + 3) begin
            errors++; $display("FAIL single_goclean got=%0d@%0d exp=1@%0d", gc_cnt, gc_cyc, N + 3);
        end
        checks++;
        if (dn_cnt !== 1 || dn_cyc !== N + 5 + 10) begin
            errors++; $display("FAIL single_done got=%0d@%0d exp=1@%0d", dn_cnt, dn_cyc, N + 15);
        end
        checks++;
        if (xLeft !== 3 || xRight !== 3 || yTop !== 2 || yBottom !== 2 || found !== 1'b1) begin
            errors++; $display("FAIL single_box got=%0d,%0d,%0d,%0d f=%b exp=3,3,2,2 f=1", xLeft, xRight, yTop, yBottom, found);
        end
        checks++;
        if (busy_first !== 1'b1 || busy_after !== 1'b0) begin
            errors++; $display("FAIL single_busy got=%b%b exp=10", busy_first, busy_after);
        end
        checks++;
        if (addr_err !== 0) begin
            errors++; $display("FAIL single_addr got=%0d exp=0", addr_err);
        end
    endtask

    task automatic test_multi_box;
        bit hit;
        fill(3'd3); mem[5][1] = 3'd4; mem[1][6] = 3'd5; mem[3][2] = 3'd6; thresh = 3'd4; clean_len = 3;
        model(thresh, hit);
        run_scan(0, 0);
        checks++;
        if (xLeft !== 1 || xRight !== 6 || yTop !== 1 || yBottom !== 5) begin
            errors++; $display("FAIL multi_box got=%0d,%0d,%0d,%0d exp=1,6,1,5", xLeft, xRight, yTop, yBottom);
        end
        checks++;
        if (dn_cyc !== N + 5 + 3 || gc_cnt !== 1) begin
            errors++; $display("FAIL multi_timing got=%0d/%0d exp=%0d/1", dn_cyc, gc_cnt, N + 8);
        end
    endtask

    task automatic test_corner;
        bit hit;
        fill(3'd0); mem[0][0] = 3'd5; mem[7][7] = 3'd5; thresh = 3'd5; clean_len = 1;
        model(thresh, hit);
        run_scan(0, 0);
        checks++;
        if (xLeft !== 0 || xRight !== 7 || yTop !== 0 || yBottom !== 7 || found !== 1'b1) begin
            errors++; $display("FAIL corner_box got=%0d,%0d,%0d,%0d f=%b exp=0,7,0,7 f=1", xLeft, xRight, yTop, yBottom, found);
        end
    endtask

    task automatic test_no_star;
        bit hit;
        fill(3'd2); thresh = 3'd3;
        model(thresh, hit);
        run_scan(0, 0);
        checks++;
        if (found !== 1'b0 || gc_cnt !== 0) begin
            errors++; $display("FAIL nostar_found got=%b/%0d exp=0/0", found, gc_cnt);
        end
        checks++;
        if (dn_cnt !== 1 || dn_cyc !== N + 3 || busy_after !== 1'b0) begin
            errors++; $display("FAIL nostar_done got=%0d@%0d exp=1@%0d", dn_cnt, dn_cyc, N + 3);
        end
        checks++;
        if (int'(xLeft) != exp_xl || int'(xRight) != exp_xr || int'(yTop) != exp_yt || int'(yBottom) != exp_yb) begin
            errors++; $display("FAIL nostar_box_held got=%0d,%0d,%0d,%0d exp=%0d,%0d,%0d,%0d",
                               xLeft, xRight, yTop, yBottom, exp_xl, exp_xr, exp_yt, exp_yb);
        end
    endtask

    task automatic test_thresh_zero;
        bit hit;
        fill(3'd0); thresh = 3'd0; clean_len = 2;
        model(thresh, hit);
        run_scan(0, 0);
        checks++;
        if (xLeft !== 0 || xRight !== 7 || yTop !== 0 || yBottom !== 7 || found !== 1'b1) begin
            errors++; $display("FAIL thresh0_box got=%0d,%0d,%0d,%0d f=%b exp=0,7,0,7 f=1", xLeft, xRight, yTop, yBottom, found);
        end
    endtask

    task automatic test_start_while_busy;
        bit hit;
        fill(3'd0); mem[4][6] = 3'd6; thresh = 3'd6; clean_len = 10;
        model(thresh, hit);
        run_scan(10, 68);
        checks++;
        if (gc_cnt !== 1 || dn_cnt !== 1 || dn_cyc !== N + 15) begin
            errors++; $display("FAIL busy_start_pulses got=gc%0d dn%0d@%0d exp=gc1 dn1@%0d", gc_cnt, dn_cnt, dn_cyc, N + 15);
        end
        checks++;
        if (busy !== 1'b0 || xLeft !== 6 || yTop !== 4) begin
            errors++; $display("FAIL busy_start_idle got=b%b x%0d y%0d exp=b0 x6 y4", busy, xLeft, yTop);
        end
    endtask

    task automatic test_reset_mid;
        bit hit;
        fill(3'd0); mem[1][2] = 3'd7; thresh = 3'd7; clean_len = 4;
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        resetn = 1'b0;
        #1;
        checks++;
        if ({rdX, rdY, xLeft, xRight, yTop, yBottom} !== 18'd0 || {goClean, busy, found, done} !== 4'd0) begin
            errors++; $display("FAIL midreset_outputs got=%h/%b exp=0/0000",
                               {rdX, rdY, xLeft, xRight, yTop, yBottom}, {goClean, busy, found, done});
        end
        exp_xl = 0; exp_xr = 0; exp_yt = 0; exp_yb = 0;
        @(negedge clk);
        resetn = 1'b1;
        model(thresh, hit);
        run_scan(0, 0);
        checks++;
        if (xLeft !== 2 || xRight !== 2 || yTop !== 1 || yBottom !== 1 || found !== 1'b1 || dn_cyc !== N + 9 || addr_err !== 0) begin
            errors++; $display("FAIL midreset_rescan got=%0d,%0d,%0d,%0d f=%b d@%0d a%0d exp=2,2,1,1 f=1 d@%0d a0",
                               xLeft, xRight, yTop, yBottom, found, dn_cyc, addr_err, N + 9);
        end
    endtask

    task automatic test_random;
        bit hit;
        int dens, exp_dn;
        for (int it = 0; it < 8; it++) begin
            dens = (it % 2 == 0) ? 3 : 30;
            for (int y = 0; y < 8; y++)
                for (int x = 0; x < 8; x++)
                    mem[y][x] = ($urandom_range(0, 99) < dens) ? 3'($urandom_range(0, 7)) : 3'd0;
            thresh = 3'($urandom_range(1, 7));
            clean_len = $urandom_range(1, 6);
            model(thresh, hit);
            exp_dn = hit ? N + 5 + clean_len : N + 3;
            run_scan(0, 0);
            checks++;
            if (found !== hit || gc_cnt !== int'(hit) || dn_cnt !== 1 || dn_cyc !== exp_dn) begin
                errors++; $display("FAIL rand%0d_flow got=f%b gc%0d dn%0d@%0d exp=f%b gc%0d dn1@%0d",
                                   it, found, gc_cnt, dn_cnt, dn_cyc, hit, int'(hit), exp_dn);
            end
            checks++;
            if (int'(xLeft) != exp_xl || int'(xRight) != exp_xr || int'(yTop) != exp_yt || int'(yBottom) != exp_yb) begin
                errors++; $display("FAIL rand%0d_box got=%0d,%0d,%0d,%0d exp=%0d,%0d,%0d,%0d",
                                   it, xLeft, xRight, yTop, yBottom, exp_xl, exp_xr, exp_yt, exp_yb);
            end
        end
    endtask

    initial begin
        fill(3'd0);
        repeat (3) @(negedge clk);
        test_reset();
        resetn = 1'b1;
        test_single_star();
        test_multi_box();
        test_corner();
        test_no_star();
        test_thresh_zero();
        test_start_while_busy();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/star_box_finder.md
# star_box_finder

Scans the stored image in raster order, thresholds each pixel, and computes the bounding box of all pixels at or above a brightness threshold. It sits directly upstream of the box-cleaning stage. When a star is found, it drives that stage's box inputs (xLeft/xRight/yTop/yBottom) and runs the goClean/doneClean handshake. It then reports completion to the top-level controller.

## Interface
Parameters:
- xSz, 3, x coordinate width
- ySz, 3, y coordinate width
- colSz, 3, pixel colour/brightness width
- XMAX, 7, last x coordinate scanned (XMAX < 2^xSz)
- YMAX, 7, last y coordinate scanned (YMAX < 2^ySz)

Ports:
- clk  in  1  clock; all state changes on rising edge
- resetn  in  1  reset, asynchronous, active-low
- start  in  1  begin a scan; sampled only in IDLE
- thresh  in  colSz  brightness threshold; must be held stable during a scan
- rdX  out  xSz  image memory read x address
- rdY  out  ySz  image memory read y address
- rdData  in  colSz  pixel at the (rdX,rdY) presented in the previous cycle (1-cycle read latency)
- xLeft, xRight  out  xSz  box column bounds (inclusive) to the cleaner
- yTop, yBottom  out  ySz  box row bounds (inclusive) to the cleaner
- goClean  out  1  one-cycle pulse requesting the cleaner to run
- doneClean  in  1  cleaner idle/complete flag (high while the cleaner is idle)
- busy  out  1  high in every state except IDLE
- found  out  1  result of the last scan; held until the next accepted start
- done  out  1  one-cycle pulse at the end of every scan

## Operation
- States: IDLE, SCAN, DRAIN, EVAL, GO_CLEAN, WAIT_LOW, WAIT_HIGH, DONE.
- IDLE -> SCAN on start. On that transition:
  - rdX/rdY are loaded to (0,0).
  - minX/minY are loaded to all-ones and maxX/maxY to 0.
  - hit is cleared and found is cleared.
- SCAN presents one address per cycle, x fastest: x increments; at x==XMAX, x wraps to 0 and y increments. SCAN -> DRAIN after presenting (XMAX,YMAX).
- Sample pipeline:
  - A valid flag and the registered address (sx,sy) track the address presented in the previous cycle.
  - A sample is processed in every cycle where valid=1, i.e. SCAN cycles 2..N and DRAIN.
  - Processing: if rdData >= thresh (unsigned), set hit and update minX=min(minX,sx), maxX=max(maxX,sx), minY=min(minY,sy), maxY=max(maxY,sy).
- DRAIN processes the last sample and goes to EVAL.
- EVAL:
  - found <= hit.
  - If hit: xLeft<=minX, xRight<=maxX, yTop<=minY, yBottom<=maxY, then go to GO_CLEAN.
  - Else go to DONE; box outputs keep their previous values.
- GO_CLEAN asserts goClean for exactly one cycle, then -> WAIT_LOW.
- WAIT_LOW waits for doneClean==0, i.e. the cleaner has left idle, then -> WAIT_HIGH.
- WAIT_HIGH waits for doneClean==1, then -> DONE.
- DONE asserts done for one cycle, then -> IDLE.
- Box outputs are stable from EVAL until the next EVAL with hit=1, so they stay constant throughout the cleaner's run.
- start is ignored outside IDLE.
- thresh=0 marks every pixel, giving box (0,0)-(XMAX,YMAX).
- Async reset at any time, including mid-scan or mid-handshake:
  - State goes to IDLE.
  - rdX, rdY, xLeft, xRight, yTop, yBottom are 0.
  - goClean, busy, found, done are 0.
  - valid and hit are 0.

## Timing
- Let N=(XMAX+1)(YMAX+1); the default N=64.
- start is high in cycle 0 (IDLE). SCAN runs cycles 1..N, presenting address k-1 in raster order at cycle k.
- DRAIN is cycle N+1 and EVAL is cycle N+2.
- No hit: DONE is cycle N+3, so done pulses at cycle 67 with defaults.
- Hit: goClean is high in cycle N+3 only; WAIT_LOW starts at N+4.
  - With the standard cleaner, doneClean falls at N+4, so WAIT_HIGH begins at N+5.
  - done pulses the cycle after doneClean is first seen high in WAIT_HIGH.
- busy rises the cycle after start is accepted and falls the cycle after DONE.
- Registered outputs change only on clock edges (or asynchronously on reset).

## Test plan
- Single star: only pixel (3,2)=7, thresh=4, all others 0 -> goClean pulses once at cycle 67; box (3,3,2,2); found=1. Then model the cleaner as doneClean low for 10 cycles, then high -> one done pulse, busy falls.
- Multi-pixel box: pixels (1,5)=4, (6,1)=5, (2,3)=6, thresh=4 (tests equality) -> box xLeft=1, xRight=6, yTop=1, yBottom=5.
- Corner/drain: pixels (0,0) and (7,7) only -> box (0,7,0,7). This confirms the last sample is processed in DRAIN.
- No star: all pixels 2, thresh=3 -> found=0, goClean never asserts, done at cycle 67, box outputs unchanged from the previous run.
- Reset mid-scan: assert resetn=0 at cycle 30 -> all outputs 0 immediately, state IDLE. A new start then yields a correct full scan.
- start re-asserted while busy: pulse start at cycles 10 and 68 (during WAIT_LOW) -> ignored. Exactly one goClean and one done per accepted start.
